pc_branch_sequencer: RTL and testbench
======================================

PC_BRANCH_SEQUENCER -- requirements
Module: pc_branch_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: address width of the PC and every target.
REQ-002 Parameter RAS_DEPTH, default 8 (power of two, ≥2): return-address-stack entries.
REQ-003 Parameter INC, default 4: sequential PC increment.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  advance; when low, PC and RAS hold.
REQ-008 isBranch  in  1  current instruction is a control-transfer.
REQ-009 validJump  in  1  branch condition satisfied.
REQ-010 labelSel  in  1  0: use label0, 1: use label1.
REQ-011 jumpAddr  in  1  1: register target rsAddr; 0: PC-relative label target.
REQ-012 isCall  in  1  taken transfer pushes the return address.
REQ-013 isRet  in  1  taken transfer pops the return address.
REQ-014 label0  in  26  signed offset, sign-extended to WIDTH.
REQ-015 label1  in  16  signed offset, sign-extended to WIDTH.
REQ-016 rsAddr  in  WIDTH  register-sourced absolute target.
REQ-017 pc  out  WIDTH  registered current PC.
REQ-018 nextAddr  out  WIDTH  combinational address loaded on the next enabled edge.
REQ-019 rasEmpty / rasFull  out  1 each  registered RAS occupancy flags.
REQ-020 rasUnderflow  out  1  registered one-cycle pulse: a return popped an empty RAS.

Function
REQ-021 taken = isBranch & validJump; isCall and isRet have no effect when taken=0.
REQ-022 nextAddr priority: not taken → pc+INC; taken & isRet & !rasEmpty → RAS top; taken & jumpAddr → rsAddr; taken → pc + sext(label0 or label1 per labelSel).
REQ-023 taken & isRet & rasEmpty → target falls back to the rsAddr/label rule of REQ-022, and rasUnderflow=1 for the following cycle.
REQ-024 All additions are modulo 2^WIDTH; wrap-around is silent.
REQ-025 On an enabled edge, pc ← nextAddr; latency of a redirect is one cycle.
REQ-026 Push (taken & isCall & !isRet) writes pc+INC at top, count+1.
REQ-027 Push when full overwrites the oldest entry (circular pointer); count stays RAS_DEPTH; rasFull stays 1.
REQ-028 Pop (taken & isRet & !isCall & !rasEmpty) decrements count; the popped entry is not cleared.
REQ-029 Simultaneous isCall & isRet (taken): pop then push — top entry is replaced with pc+INC; count unchanged; when empty, acts as a plain push.
REQ-030 en=0: pc, RAS, and flags hold; rasUnderflow deasserts; nextAddr still reflects current inputs.
REQ-031 rasEmpty = (count==0) and rasFull = (count==RAS_DEPTH), both updated on the same edge as count.

Reset
REQ-032 rst=1 immediately forces pc=RESET_PC, count=0, rasEmpty=1, rasFull=0, rasUnderflow=0, independent of clk.
REQ-033 RAS entry storage is not reset; contents are unobservable while count=0.
REQ-034 Reset asserted mid-sequence discards any pending push/pop; the first enabled edge after release loads nextAddr computed from RESET_PC.

Structure
REQ-035 Shared package holds the target-select enum (SEQ, LABEL, REG, RAS) and the default WIDTH/RAS_DEPTH/INC constants.
REQ-036 A single sub-module, return_addr_stack (circular buffer, push/pop/overwrite, count, flags), sits beside the PC register and target mux.

Verification
REQ-037 Reset → pc=0, rasEmpty=1; en=1, no branch for 3 cycles → pc = 4, 8, 12.
REQ-038 pc=0x100, taken, labelSel=1, label1=0xFFF0 → next pc=0x0F0; label0=0x0000010 with labelSel=0 → pc+0x10.
REQ-039 pc=0x200, taken call jumpAddr=1 rsAddr=0x800 → pc=0x800 and RAS top=0x204; then taken ret → pc=0x204, rasEmpty=1.
REQ-040 9 consecutive calls (RAS_DEPTH=8) → rasFull=1; 8 returns yield the newest 8 return addresses in LIFO order; the 9th return has an empty RAS → rasUnderflow pulses and the fallback target is used.
REQ-041 taken call+ret together with 3 entries → count stays 3, top=pc+INC; en=0 during a taken call → pc and count unchanged.
REQ-042 pc=0xFFFFFFFC with no branch → pc=0x00000000; rst pulsed mid-call between edges → pc=0 asynchronously, count=0.

Source files
------------

// File: rtl/pc_branch_sequencer_pkg.sv
// Shared types and default sizing for the PC/branch sequencer.
// Target-select encoding used by the next-address mux.
package pc_branch_sequencer_pkg;

    localparam int DefWidth    = 32;
    localparam int DefRasDepth = 8;
    localparam int DefInc      = 4;

    typedef enum logic [1:0] {
        SEQ,
        LABEL,
        REG,
        RAS
    } tgtSel_e;

endpackage

// File: rtl/pc_branch_sequencer_ras.sv
// Circular return-address stack with overwrite-on-full.
// Registered occupancy flags and a one-cycle underflow pulse.
module return_addr_stack
    import pc_branch_sequencer_pkg::*;
#(
    parameter int WIDTH = DefWidth,
    parameter int DEPTH = DefRasDepth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] topData,
    output logic             empty,
    output logic             full,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    topPtr;
    logic [PW-1:0]    topPtrNext;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic             wrEn;

    always_comb begin
        topPtrNext = topPtr;
        countNext  = count;
        wrEn       = 1'b0;
        wrPtr      = topPtr + 1'b1;
        if (push && pop && !empty) begin
            // pop-then-push collapses into replacing the top entry
            wrEn  = 1'b1;
            wrPtr = topPtr;
        end else if (push) begin
            wrEn       = 1'b1;
            topPtrNext = topPtr + 1'b1;
            if (!full) begin
                countNext = count + 1'b1;
            end
        end else if (pop && !empty) begin
            topPtrNext = topPtr - 1'b1;
            countNext  = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topPtr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            topPtr    <= topPtrNext;
            count     <= countNext;
            empty     <= (countNext == '0);
            full      <= (countNext == CW'(DEPTH));
            underflow <= pop && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign topData = mem[topPtr];

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program counter with branch/jump/call/return target selection.
// Returns are predicted from a small circular return-address stack.
module pc_branch_sequencer
    import pc_branch_sequencer_pkg::*;
#(
    parameter int               WIDTH     = DefWidth,
    parameter int               RAS_DEPTH = DefRasDepth,
    parameter int               INC       = DefInc,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             isBranch,
    input  logic             validJump,
    input  logic             labelSel,
    input  logic             jumpAddr,
    input  logic             isCall,
    input  logic             isRet,
    input  logic [25:0]      label0,
    input  logic [15:0]      label1,
    input  logic [WIDTH-1:0] rsAddr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] nextAddr,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasUnderflow
);

    logic             taken;
    logic             push;
    logic             pop;
    tgtSel_e          sel;
    logic [WIDTH-1:0] pcInc;
    logic [WIDTH-1:0] lab0Ext;
    logic [WIDTH-1:0] lab1Ext;
    logic [WIDTH-1:0] labelOff;
    logic [WIDTH-1:0] rasTop;

    assign taken    = isBranch & validJump;
    assign push     = en & taken & isCall;
    assign pop      = en & taken & isRet;
    assign pcInc    = pc + WIDTH'(INC);
    assign lab0Ext  = WIDTH'(signed'(label0));
    assign lab1Ext  = WIDTH'(signed'(label1));
    assign labelOff = labelSel ? lab1Ext : lab0Ext;

    // an empty-stack return falls through to the register/label target
    always_comb begin
        sel = SEQ;
        if (taken) begin
            if (isRet && !rasEmpty) begin
                sel = RAS;
            end else if (jumpAddr) begin
                sel = REG;
            end else begin
                sel = LABEL;
            end
        end
    end

    always_comb begin
        nextAddr = pcInc;
        unique case (sel)
            SEQ:     nextAddr = pcInc;
            LABEL:   nextAddr = pc + labelOff;
            REG:     nextAddr = rsAddr;
            RAS:     nextAddr = rasTop;
            default: nextAddr = pcInc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= nextAddr;
        end
    end

    return_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) uRas (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .pushData  (pcInc),
        .topData   (rasTop),
        .empty     (rasEmpty),
        .full      (rasFull),
        .underflow (rasUnderflow)
    );

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Scoreboard bench for pc_branch_sequencer: directed vectors queue
// expected pc/flags; a monitor compares after each rising edge.
module tb_pc_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        isBranch;
    logic        validJump;
    logic        labelSel;
    logic        jumpAddr;
    logic        isCall;
    logic        isRet;
    logic [25:0] label0;
    logic [15:0] label1;
    logic [31:0] rsAddr;
    logic [31:0] pc;
    logic [31:0] nextAddr;
    logic        rasEmpty;
    logic        rasFull;
    logic        rasUnderflow;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        u;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    pc_branch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .isBranch     (isBranch),
        .validJump    (validJump),
        .labelSel     (labelSel),
        .jumpAddr     (jumpAddr),
        .isCall       (isCall),
        .isRet        (isRet),
        .label0       (label0),
        .label1       (label1),
        .rsAddr       (rsAddr),
        .pc           (pc),
        .nextAddr     (nextAddr),
        .rasEmpty     (rasEmpty),
        .rasFull      (rasFull),
        .rasUnderflow (rasUnderflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drv(input logic e, b, v, ls, ja, c, r,
                       input logic [25:0] l0, input logic [15:0] l1,
                       input logic [31:0] rs);
        en = e; isBranch = b; validJump = v; labelSel = ls;
        jumpAddr = ja; isCall = c; isRet = r;
        label0 = l0; label1 = l1; rsAddr = rs;
    endtask

    task automatic expq(input string n, input logic [31:0] p,
                        input logic xe, xf, xu);
        exp_t x;
        x.name = n; x.pc = p; x.e = xe; x.f = xf; x.u = xu;
        sbq.push_back(x);
    endtask

    task automatic cyc(input string n, input logic e, b, v, ls, ja, c, r,
                       input logic [25:0] l0, input logic [15:0] l1,
                       input logic [31:0] rs, input logic [31:0] p,
                       input logic xe, xf, xu);
        @(negedge clk);
        drv(e, b, v, ls, ja, c, r, l0, l1, rs);
        expq(n, p, xe, xf, xu);
        @(posedge clk);
    endtask

    task automatic seqStep(input string n, input logic [31:0] p,
                           input logic xe, xf, xu);
        cyc(n, 1, 0, 0, 0, 0, 0, 0, '0, '0, '0, p, xe, xf, xu);
    endtask

    task automatic jreg(input string n, input logic c, r,
                        input logic [31:0] rs, input logic [31:0] p,
                        input logic xe, xf, xu);
        cyc(n, 1, 1, 1, 0, 1, c, r, '0, '0, rs, p, xe, xf, xu);
    endtask

    // monitor: one queued expectation is consumed after each rising edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk({x.name, ".pc"}, pc, x.pc);
                chk({x.name, ".empty"}, {31'b0, rasEmpty}, {31'b0, x.e});
                chk({x.name, ".full"}, {31'b0, rasFull}, {31'b0, x.f});
                chk({x.name, ".uf"}, {31'b0, rasUnderflow}, {31'b0, x.u});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        #12;
        chk("rst.pc", pc, 32'h0);
        chk("rst.empty", {31'b0, rasEmpty}, 32'h1);
        chk("rst.full", {31'b0, rasFull}, 32'h0);
        chk("rst.uf", {31'b0, rasUnderflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        seqStep("seq1", 32'h4, 1, 0, 0);
        seqStep("seq2", 32'h8, 1, 0, 0);
        seqStep("seq3", 32'hC, 1, 0, 0);

        jreg("to100", 0, 0, 32'h100, 32'h100, 1, 0, 0);
        cyc("lab1", 1, 1, 1, 1, 0, 0, 0, 26'h0, 16'hFFF0, 32'h0,
            32'hF0, 1, 0, 0);
        cyc("lab0", 1, 1, 1, 0, 0, 0, 0, 26'h10, 16'h0, 32'h0,
            32'h100, 1, 0, 0);
        cyc("notTaken", 1, 1, 0, 0, 1, 1, 0, 26'h0, 16'h0, 32'h999,
            32'h104, 1, 0, 0);

        jreg("to200", 0, 0, 32'h200, 32'h200, 1, 0, 0);
        jreg("call800", 1, 0, 32'h800, 32'h800, 0, 0, 0);
        jreg("ret204", 0, 1, 32'hBAD0, 32'h204, 1, 0, 0);

        for (int i = 0; i < 9; i++) begin
            jreg($sformatf("call%0d", i), 1, 0,
                 32'h1000 + i * 32'h100, 32'h1000 + i * 32'h100,
                 0, (i >= 7), 0);
        end
        for (int j = 0; j < 8; j++) begin
            jreg($sformatf("ret%0d", j), 0, 1, 32'h4440,
                 32'h1704 - j * 32'h100, (j == 7), 0, 0);
        end
        jreg("retUf", 0, 1, 32'h4440, 32'h4440, 1, 0, 1);
        seqStep("afterUf", 32'h4444, 1, 0, 0);

        jreg("cA", 1, 0, 32'h5000, 32'h5000, 0, 0, 0);
        jreg("cB", 1, 0, 32'h6000, 32'h6000, 0, 0, 0);
        jreg("cC", 1, 0, 32'h7000, 32'h7000, 0, 0, 0);
        jreg("callRet", 1, 1, 32'h9990, 32'h6004, 0, 0, 0);
        jreg("rA", 0, 1, 32'h9990, 32'h7004, 0, 0, 0);
        jreg("rB", 0, 1, 32'h9990, 32'h5004, 0, 0, 0);
        jreg("rC", 0, 1, 32'h9990, 32'h4448, 1, 0, 0);

        cyc("enLow", 0, 1, 1, 0, 1, 1, 0, '0, '0, 32'h9000,
            32'h4448, 1, 0, 0);
        #2;
        chk("enLow.nextAddr", nextAddr, 32'h9000);
        seqStep("afterEnLow", 32'h444C, 1, 0, 0);

        jreg("toTop", 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
        seqStep("wrap", 32'h0, 1, 0, 0);

        jreg("to300", 0, 0, 32'h300, 32'h300, 1, 0, 0);
        jreg("call400", 1, 0, 32'h400, 32'h400, 0, 0, 0);
        @(negedge clk);
        drv(1, 1, 1, 0, 1, 1, 0, '0, '0, 32'h500);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.pc", pc, 32'h0);
        chk("arst.empty", {31'b0, rasEmpty}, 32'h1);
        chk("arst.full", {31'b0, rasFull}, 32'h0);
        drv(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
        #1;
        rst = 1'b0;
        expq("postRst", 32'h4, 1, 0, 0);
        @(posedge clk);
        seqStep("postRst2", 32'h8, 1, 0, 0);

        @(negedge clk);
        @(posedge clk);
        #3;
        chk("drain", sbq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
